tl45_muldiv: RTL and testbench
==============================

# tl45_muldiv

Parametrised iterative multiply/divide execute unit for the TL45 core. It sits in the execute stage beside the ALU and handles MUL, signed and unsigned DIV, and signed and unsigned REM. It replaces the fixed-wait multiply with a configurable-width shift/add and restoring-divide engine. While busy it stalls upstream stages, and it forwards its result on the same operand-forward bus as the ALU.

## Interface
- XLEN, default 32: operand and result width; must be ≥ 4 and even.
- REG_BITS, default 4: destination register index width; register 0 means "no write".
- i_clk  input  1  clock; all state changes on the rising edge.
- i_reset  input  1  reset; synchronous and active-high.
- i_pipe_stall  input  1  downstream stall; hold the output buffer.
- o_pipe_stall  output  1  stall to upstream stages.
- i_pipe_flush  input  1  flush request from downstream.
- o_pipe_flush  output  1  flush forwarded upstream; equals i_pipe_flush.
- i_opcode  input  5  TL45 opcode.
- i_dr  input  REG_BITS  destination register.
- i_sr1_val  input  XLEN  operand A (multiplicand / dividend).
- i_sr2_val  input  XLEN  operand B (multiplier / divisor).
- o_of_reg  output  REG_BITS  operand-forward register; 0 when no valid result.
- o_of_val  output  XLEN  operand-forward value; 0 when o_of_reg is 0.
- o_dr  output  REG_BITS  registered destination register to the next stage.
- o_value  output  XLEN  registered result to the next stage.

## Operation
- Opcodes handled:
  - MUL 5'h03: low XLEN bits of A*B.
  - DIV 5'h0F: signed quotient.
  - DIVU 5'h10: unsigned quotient.
  - REM 5'h11: signed remainder.
  - REMU 5'h12: unsigned remainder.
  - All other opcodes are non-MD.
- Non-MD opcode behaviour:
  - No stall contribution.
  - o_of_reg=0.
  - Next edge writes o_dr=0, o_value=0 (unless i_pipe_stall).
- FSM states: IDLE, BUSY, DONE.
- IDLE, MD opcode present, no flush:
  - Latch op, dr, |A|, |B| (signed ops take magnitudes).
  - Record quotient sign = sA^sB and remainder sign = sA.
  - Set count=XLEN, go to BUSY.
  - Write o_dr=0, o_value=0.
- BUSY, MUL: one shift/add step per cycle, LSB-first on B.
- BUSY, DIV/REM: one restoring step per cycle, MSB-first.
- BUSY exit: decrement count; when count reaches 0, go to DONE.
- DONE:
  - Result is combinationally valid.
  - Signed fix-up: negate quotient if qsign=1; negate remainder if rsign=1.
  - o_of_reg=latched dr, o_of_val=result.
  - If !i_pipe_stall: edge writes o_dr/o_value = dr/result and returns to IDLE.
  - If i_pipe_stall: hold DONE, keep forwarding.
- Stall rule: o_pipe_stall = i_pipe_stall | (MD opcode present & state≠DONE).
- Upstream must hold i_* stable while o_pipe_stall is high; the unit ignores input changes outside IDLE.
- Divide by zero:
  - Quotient = all ones.
  - Remainder = A (unsigned, or signed original).
  - No trap.
- Signed overflow (A = most-negative, B = −1): quotient = A, remainder = 0.
- Flush or reset in any state:
  - Next edge forces IDLE, count=0, o_dr=0, o_value=0.
  - An in-flight operation is discarded.
- Reset and flush are not blocked by i_pipe_stall.
- Reset values: state IDLE, o_dr=0, o_value=0, and therefore o_of_reg=0, o_of_val=0 (with no MD opcode).
- Internal state widths: XLEN-bit accumulator/remainder and quotient registers, ceil(log2(XLEN+1))-bit counter.

## Timing
- Issue cycle C0 (IDLE), BUSY cycles C1..C_XLEN, DONE cycle C_XLEN+1.
- o_pipe_stall is high C0..C_XLEN (XLEN+1 cycles), low in DONE if i_pipe_stall=0.
- o_of_* are valid during C_XLEN+1.
- o_dr/o_value are visible from C_XLEN+2.
- Back-to-back MD ops: the next op enters IDLE at C_XLEN+2; no overlap.
- Flush during C0: the op is never latched; o_pipe_stall follows the flushed (zero) inputs next cycle.
- Flush asserted in the same cycle as DONE-complete: flush wins, o_dr=0.

## Test plan
- XLEN=32, MUL A=7 B=6 dr=3 at C0 → stall high 33 cycles; o_of_reg=3, o_of_val=42 at C33; o_dr=3, o_value=42 at C34.
- DIV A=−7 B=2 → quotient 0xFFFFFFFD (−3); REM same operands → 0xFFFFFFFF (−1); DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU A=5 B=0 → 0xFFFFFFFF; REMU A=5 B=0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- MUL issued, i_pipe_flush pulsed at C10 → next cycle IDLE, o_dr=0, o_pipe_stall=0 with opcode 0; no later writeback.
- i_pipe_stall held 3 cycles at DONE → o_of_* held stable, o_dr/o_value unchanged; written one edge after release.
- XLEN=16 build: MUL 0x0100*0x0100 → 0x0000; DIVU 0xFFFF/0x0003 → 0x5555 with 17 stall cycles; ADD opcode → no stall, o_dr=0.

Source files
------------

// File: rtl/tl45_muldiv.sv
// tl45_muldiv: iterative multiply / divide execute unit for the TL45 core.
//
// Handles MUL (low XLEN bits), DIV/DIVU (quotient) and REM/REMU (remainder).
// Multiply is a shift/add engine, LSB-first on operand B. Divide is a
// restoring divider, MSB-first. Both take XLEN cycles. Signed divides work on
// magnitudes, and the signs are fixed up when the result is presented.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_pipe_stall           downstream stall, holds o_dr/o_value (and DONE)
//   o_pipe_stall           stall to upstream while an MD op is incomplete
//   i_pipe_flush           flush request, discards any in-flight op
//   o_pipe_flush           flush forwarded upstream (= i_pipe_flush)
//   i_opcode, i_dr         TL45 opcode and destination register
//   i_sr1_val, i_sr2_val   operand A (multiplicand/dividend), B (multiplier/divisor)
//   o_of_reg, o_of_val     operand-forward bus, valid in DONE only
//   o_dr, o_value          registered writeback to the next stage
module tl45_muldiv #(
   parameter int XLEN     = 32,
   parameter int REG_BITS = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_pipe_stall,
   output logic                o_pipe_stall,
   input  logic                i_pipe_flush,
   output logic                o_pipe_flush,
   input  logic [4:0]          i_opcode,
   input  logic [REG_BITS-1:0] i_dr,
   input  logic [XLEN-1:0]     i_sr1_val,
   input  logic [XLEN-1:0]     i_sr2_val,
   output logic [REG_BITS-1:0] o_of_reg,
   output logic [XLEN-1:0]     o_of_val,
   output logic [REG_BITS-1:0] o_dr,
   output logic [XLEN-1:0]     o_value
);

   localparam int CW = $clog2(XLEN + 1);

   localparam logic [4:0] OPC_MUL  = 5'h03;
   localparam logic [4:0] OPC_DIV  = 5'h0F;
   localparam logic [4:0] OPC_DIVU = 5'h10;
   localparam logic [4:0] OPC_REM  = 5'h11;
   localparam logic [4:0] OPC_REMU = 5'h12;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   typedef enum logic [1:0] {K_MUL, K_DIV, K_REM} kind_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   kind_t                 kind_q;
   logic [REG_BITS-1:0]   dr_q;
   logic [XLEN-1:0]       a_q;      // multiplicand, shifted left each MUL step
   logic [XLEN-1:0]       b_q;      // multiplier (shifted right) or divisor
   logic [XLEN-1:0]       acc_q;    // product accumulator / partial remainder
   logic [XLEN-1:0]       quo_q;    // dividend bits shift out, quotient bits shift in
   logic                  qsign_q;
   logic                  rsign_q;
   logic                  bzero_q;

   // Opcode decode
   logic                  is_md;
   kind_t                 kind_in;
   logic                  signed_in;

   // NOTE: every always_comb output gets a default first so that no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      is_md     = 1'b1;
      kind_in   = K_MUL;
      signed_in = 1'b0;
      case (i_opcode)
         OPC_MUL:  kind_in = K_MUL;
         OPC_DIV:  begin kind_in = K_DIV; signed_in = 1'b1; end
         OPC_DIVU: kind_in = K_DIV;
         OPC_REM:  begin kind_in = K_REM; signed_in = 1'b1; end
         OPC_REMU: kind_in = K_REM;
         default:  is_md = 1'b0;
      endcase
   end

   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;

   assign a_neg = signed_in & i_sr1_val[XLEN-1];
   assign b_neg = signed_in & i_sr2_val[XLEN-1];
   assign a_mag = a_neg ? -i_sr1_val : i_sr1_val;
   assign b_mag = b_neg ? -i_sr2_val : i_sr2_val;

   // One restoring-divide step: shift the next dividend bit into the partial
   // remainder and subtract the divisor if it fits. The shifted value needs
   // XLEN+1 bits because the remainder can reach divisor-1 before the shift.
   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   rem_diff;
   logic            rem_take;

   assign rem_sh   = {acc_q, quo_q[XLEN-1]};
   assign rem_diff = rem_sh - {1'b0, b_q};
   assign rem_take = (rem_sh >= {1'b0, b_q});

   // Result with signed fix-up; divide by zero forces an all-ones quotient
   // regardless of the dividend sign.
   logic [XLEN-1:0] result;

   always_comb begin
      result = acc_q;
      case (kind_q)
         K_DIV:   result = bzero_q ? '1 : (qsign_q ? -quo_q : quo_q);
         K_REM:   result = rsign_q ? -acc_q : acc_q;
         default: result = acc_q;
      endcase
   end

   // Control state and writeback buffer.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_pipe_flush) begin
         state   <= S_IDLE;
         cnt     <= '0;
         o_dr    <= '0;
         o_value <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (is_md) begin
                  state <= S_BUSY;
                  cnt   <= CW'(XLEN);
               end
            end
            S_BUSY: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= S_DONE;
            end
            S_DONE: begin
               if (!i_pipe_stall) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (!i_pipe_stall) begin
            o_dr    <= (state == S_DONE) ? dr_q   : '0;
            o_value <= (state == S_DONE) ? result : '0;
         end
      end
   end

   // Datapath registers.
   // NOTE: the datapath has no reset; it is always reloaded at issue and is
   // only observed in DONE, which reset and flush cannot reach directly.
   always_ff @(posedge i_clk) begin
      if (state == S_IDLE && is_md) begin
         kind_q  <= kind_in;
         dr_q    <= i_dr;
         a_q     <= a_mag;
         b_q     <= b_mag;
         acc_q   <= '0;
         quo_q   <= a_mag;
         qsign_q <= a_neg ^ b_neg;
         rsign_q <= a_neg;
         bzero_q <= (i_sr2_val == '0);
      end else if (state == S_BUSY) begin
         if (kind_q == K_MUL) begin
            acc_q <= acc_q + (b_q[0] ? a_q : '0);
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
         end else begin
            acc_q <= rem_take ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], rem_take};
         end
      end
   end

   assign o_pipe_stall = i_pipe_stall | (is_md & (state != S_DONE));
   assign o_pipe_flush = i_pipe_flush;
   assign o_of_reg     = (state == S_DONE) ? dr_q : '0;
   assign o_of_val     = (state == S_DONE && dr_q != '0) ? result : '0;

endmodule

// File: tb/tb_tl45_muldiv.sv
// Testbench for tl45_muldiv: one XLEN=32 and one XLEN=16 instance share the
// clock, reset, downstream stall and flush. Directed cases come first, then
// randomized operations scored against a plain-arithmetic reference model.
module tb_tl45_muldiv;

   localparam logic [4:0] MUL  = 5'h03;
   localparam logic [4:0] DIV  = 5'h0F;
   localparam logic [4:0] DIVU = 5'h10;
   localparam logic [4:0] REM  = 5'h11;
   localparam logic [4:0] REMU = 5'h12;
   localparam logic [4:0] ADD  = 5'h01;

   logic        clk = 1'b0;
   logic        rst;
   logic        pstall;
   logic        pflush;

   logic [4:0]  op32, op16;
   logic [3:0]  dr32, dr16;
   logic [31:0] a32, b32;
   logic [15:0] a16, b16;

   logic        st32, st16, fl32, fl16;
   logic [3:0]  ofr32, ofr16, odr32, odr16;
   logic [31:0] ofv32, oval32;
   logic [15:0] ofv16, oval16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tl45_muldiv #(.XLEN(32), .REG_BITS(4)) dut32 (
      .i_clk(clk), .i_reset(rst), .i_pipe_stall(pstall), .o_pipe_stall(st32),
      .i_pipe_flush(pflush), .o_pipe_flush(fl32), .i_opcode(op32), .i_dr(dr32),
      .i_sr1_val(a32), .i_sr2_val(b32), .o_of_reg(ofr32), .o_of_val(ofv32),
      .o_dr(odr32), .o_value(oval32));

   tl45_muldiv #(.XLEN(16), .REG_BITS(4)) dut16 (
      .i_clk(clk), .i_reset(rst), .i_pipe_stall(pstall), .o_pipe_stall(st16),
      .i_pipe_flush(pflush), .o_pipe_flush(fl16), .i_opcode(op16), .i_dr(dr16),
      .i_sr1_val(a16), .i_sr2_val(b16), .o_of_reg(ofr16), .o_of_val(ofv16),
      .o_dr(odr16), .o_value(oval16));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: the architectural result from plain integer arithmetic.
   function automatic logic [31:0] ref_md(input int xl, input logic [4:0] opc,
                                          input logic [31:0] a, input logic [31:0] b);
      longint unsigned mask, ua, ub, r;
      longint          sa, sb;
      mask = (64'd1 << xl) - 64'd1;
      ua   = 64'(a) & mask;
      ub   = 64'(b) & mask;
      sa   = (ua > (mask >> 1)) ? longint'(ua) - longint'(mask + 64'd1) : longint'(ua);
      sb   = (ub > (mask >> 1)) ? longint'(ub) - longint'(mask + 64'd1) : longint'(ub);
      case (opc)
         MUL:     r = ua * ub;
         DIV:     r = (ub == 0) ? mask : longint'(sa / sb);
         DIVU:    r = (ub == 0) ? mask : ua / ub;
         REM:     r = (ub == 0) ? ua : longint'(sa % sb);
         REMU:    r = (ub == 0) ? ua : ua % ub;
         default: r = 0;
      endcase
      return 32'(r & mask);
   endfunction

   function automatic logic       g_stall(input bit w16); return w16 ? st16 : st32; endfunction
   function automatic logic [3:0] g_ofr(input bit w16);   return w16 ? ofr16 : ofr32; endfunction
   function automatic logic [31:0] g_ofv(input bit w16);  return w16 ? 32'(ofv16) : ofv32; endfunction
   function automatic logic [3:0] g_odr(input bit w16);   return w16 ? odr16 : odr32; endfunction
   function automatic logic [31:0] g_oval(input bit w16); return w16 ? 32'(oval16) : oval32; endfunction

   task automatic drive(input bit w16, input logic [4:0] opc, input logic [3:0] dr,
                        input logic [31:0] a, input logic [31:0] b);
      if (w16) begin
         op16 = opc; dr16 = dr; a16 = a[15:0]; b16 = b[15:0];
      end else begin
         op32 = opc; dr32 = dr; a32 = a; b32 = b;
      end
   endtask

   // Issue one MD op at the current cycle (called just after a rising edge)
   // and check stall length, forwarding in DONE and the final writeback.
   task automatic do_op(input bit w16, input logic [4:0] opc, input logic [3:0] dr,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                        input int hold, input bit flush_done);
      int n = 0;
      int xl = w16 ? 16 : 32;
      drive(w16, opc, dr, a, b);
      #1;
      while (g_stall(w16) && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      check("stall_cycles", 64'(n), 64'(xl + 1));
      check("of_reg", 64'(g_ofr(w16)), 64'(dr));
      check("of_val", 64'(g_ofv(w16)), 64'(exp));
      if (hold > 0) begin
         pstall = 1'b1;
         repeat (hold) begin
            @(posedge clk); #1;
            check("hold_of_reg", 64'(g_ofr(w16)), 64'(dr));
            check("hold_of_val", 64'(g_ofv(w16)), 64'(exp));
            check("hold_o_dr", 64'(g_odr(w16)), 64'd0);
         end
         pstall = 1'b0;
      end
      if (flush_done) begin
         pflush = 1'b1;
         @(posedge clk); #1;
         pflush = 1'b0;
         drive(w16, 5'h00, 4'd0, 32'd0, 32'd0);
         check("flush_done_o_dr", 64'(g_odr(w16)), 64'd0);
         check("flush_done_of_reg", 64'(g_ofr(w16)), 64'd0);
         return;
      end
      @(posedge clk); #1;
      check("wb_o_dr", 64'(g_odr(w16)), 64'(dr));
      check("wb_o_value", 64'(g_oval(w16)), 64'(exp));
      drive(w16, 5'h00, 4'd0, 32'd0, 32'd0);
   endtask

   // Watch for any forwarding or writeback activity over a window.
   task automatic quiet_window(input bit w16, input int cycles, input string tag);
      int seen = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (g_odr(w16) != 4'd0 || g_ofr(w16) != 4'd0) seen++;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [4:0]  ops [5] = '{MUL, DIV, DIVU, REM, REMU};
      logic [31:0] ra, rb;
      logic [4:0]  ropc;
      bit          rw;

      rst = 1'b1; pstall = 1'b0; pflush = 1'b0;
      drive(1'b0, 5'h00, 4'd0, 32'd0, 32'd0);
      drive(1'b1, 5'h00, 4'd0, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_o_dr", 64'(odr32), 64'd0);
      check("rst_o_value", 64'(oval32), 64'd0);
      check("rst_of_reg", 64'(ofr32), 64'd0);
      check("rst_of_val", 64'(ofv32), 64'd0);
      check("rst_stall", 64'(st32), 64'd0);
      rst = 1'b0;

      // Directed XLEN=32 cases, issued back to back
      do_op(1'b0, MUL,  4'd3, 32'd7,          32'd6,          32'd42,         0, 1'b0);
      do_op(1'b0, DIV,  4'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  0, 1'b0);
      do_op(1'b0, REM,  4'd5, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0, 1'b0);
      do_op(1'b0, DIVU, 4'd6, 32'd100,        32'd7,          32'd14,         0, 1'b0);
      do_op(1'b0, REMU, 4'd7, 32'd100,        32'd7,          32'd2,          0, 1'b0);
      do_op(1'b0, DIVU, 4'd8, 32'd5,          32'd0,          32'hFFFF_FFFF,  0, 1'b0);
      do_op(1'b0, REMU, 4'd9, 32'd5,          32'd0,          32'd5,          0, 1'b0);
      do_op(1'b0, DIV,  4'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0, 1'b0);
      do_op(1'b0, REM,  4'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0, 1'b0);
      do_op(1'b0, DIV,  4'd3, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  0, 1'b0);
      do_op(1'b0, REM,  4'd4, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  0, 1'b0);

      // Downstream stall held for 3 cycles in DONE
      do_op(1'b0, MUL, 4'd5, 32'd123, 32'd456, 32'd56088, 3, 1'b0);

      // Flush in the middle of a multiply (cycle C10)
      drive(1'b0, MUL, 4'd6, 32'd9, 32'd9);
      repeat (10) @(posedge clk);
      #1;
      pflush = 1'b1;
      #1;
      check("flush_fwd", 64'(fl32), 64'd1);
      @(posedge clk); #1;
      pflush = 1'b0;
      drive(1'b0, 5'h00, 4'd0, 32'd0, 32'd0);
      #1;
      check("flush_mid_stall", 64'(st32), 64'd0);
      check("flush_mid_o_dr", 64'(odr32), 64'd0);
      quiet_window(1'b0, 40, "flush_mid_no_wb");

      // Flush in the issue cycle: the op is never latched
      drive(1'b0, DIVU, 4'd7, 32'd50, 32'd5);
      pflush = 1'b1;
      @(posedge clk); #1;
      pflush = 1'b0;
      drive(1'b0, 5'h00, 4'd0, 32'd0, 32'd0);
      #1;
      check("flush_c0_stall", 64'(st32), 64'd0);
      quiet_window(1'b0, 40, "flush_c0_no_wb");

      // Flush coinciding with DONE completion wins, then the unit recovers
      do_op(1'b0, DIVU, 4'd8, 32'd81, 32'd9, 32'd9, 0, 1'b1);
      do_op(1'b0, MUL,  4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);

      // XLEN=16 instance
      do_op(1'b1, MUL,  4'd3, 32'h0100, 32'h0100, 32'h0000, 0, 1'b0);
      do_op(1'b1, DIVU, 4'd4, 32'hFFFF, 32'h0003, 32'h5555, 0, 1'b0);
      do_op(1'b1, DIV,  4'd5, 32'h8000, 32'hFFFF, 32'h8000, 0, 1'b0);
      check("fwd16_flush", 64'(fl16), 64'd0);
      drive(1'b1, ADD, 4'd7, 32'd1, 32'd2);
      #1;
      check("add16_stall", 64'(st16), 64'd0);
      check("add16_of_reg", 64'(ofr16), 64'd0);
      @(posedge clk); #1;
      check("add16_o_dr", 64'(odr16), 64'd0);
      check("add16_o_value", 64'(oval16), 64'd0);
      drive(1'b1, 5'h00, 4'd0, 32'd0, 32'd0);

      // Randomized operations against the reference model
      repeat (24) begin
         rw   = 1'($urandom_range(0, 1));
         ropc = ops[$urandom_range(0, 4)];
         ra   = $urandom;
         rb   = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: ra = rw ? 32'h0000_8000 : 32'h8000_0000;
            3: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         do_op(rw, ropc, 4'($urandom_range(1, 15)), ra, rb,
               ref_md(rw ? 16 : 32, ropc, ra, rb), 0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
